// File: rtl/lcd_fifo_reader.sv
// RGB-LCD timing generator and pixel FIFO consumer with SOF-based frame alignment.
// Optional colour-bar test pattern via `define LCD_TEST_PATTERN_EN (adds input test_pat).
module lcd_fifo_reader #(
  parameter int          H_ACTIVE = 800,
  parameter int          H_FP     = 40,
  parameter int          H_SYNC   = 128,
  parameter int          H_BP     = 88,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 1,
  parameter int          V_SYNC   = 3,
  parameter int          V_BP     = 21,
  parameter logic        SYNC_POL = 1'b0,
  parameter logic [15:0] FILL_RGB = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] fifo_do,
  input  logic        fifo_empty,
`ifdef LCD_TEST_PATTERN_EN
  input  logic        test_pat,
`endif
  output logic        fifo_re,
  output logic        lcd_de,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        in_sync,
  output logic [15:0] underflow_cnt,
  output logic [7:0]  resync_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // state        | meaning
  // S_RESYNC     | draining FIFO one pop at a time, hunting for a SOF word
  // S_WAIT_FRAME | SOF word parked in skid, waiting for counter (0,0)
  // S_RUN        | locked: one pop per active pixel, SOF checked at (0,0)
  typedef enum logic [1:0] {S_RESYNC, S_WAIT_FRAME, S_RUN} state_t;
  state_t state;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active0, hs0, vs0, origin0;

  logic          pop_pending;
  logic          act1, hs1, vs1, origin1, skid_src1;
  logic [15:0]   skid;
  logic          skid_valid;
  logic [15:0]   pix1;
  logic          sof1, leave_run, take_fifo;
  logic          tp;
  logic          unused_hi_bits;

  assign unused_hi_bits = ^fifo_do[19:17];

`ifdef LCD_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic          tp1;
  logic [15:0]   pat0, pat1;
  logic [HW-1:0] bar_idx;

  assign tp      = test_pat;
  assign bar_idx = h_cnt / HW'(BAR_W);

  always_comb begin
    pat0 = 16'h0000;
    case (bar_idx)
      HW'(0): pat0 = 16'hFFFF;
      HW'(1): pat0 = 16'hFFE0;
      HW'(2): pat0 = 16'h07FF;
      HW'(3): pat0 = 16'h07E0;
      HW'(4): pat0 = 16'hF81F;
      HW'(5): pat0 = 16'hF800;
      HW'(6): pat0 = 16'h001F;
      default: pat0 = 16'h0000;
    endcase
  end
`else
  assign tp = 1'b0;
`endif

  assign active0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs0     = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs0     = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign origin0 = (h_cnt == '0) && (v_cnt == '0);

  // A returned word that breaks lock also blocks the pop being issued in
  // the same cycle, so no word belonging to the new frame is lost.
  assign sof1      = fifo_do[16];
  assign leave_run = !tp && (state == S_RUN) && pop_pending && (origin1 ? !sof1 : sof1);
  assign take_fifo = (state == S_RUN) && pop_pending && !leave_run;

  always_comb begin
    fifo_re = 1'b0;
    if (rst_n && !tp) begin
      case (state)
        S_RESYNC: fifo_re = !fifo_empty && !pop_pending;
        S_RUN:    fifo_re = active0 && !fifo_empty && !leave_run;
        default:  fifo_re = 1'b0;
      endcase
    end
  end

  always_comb begin
    pix1 = FILL_RGB;
    if (skid_src1)
      pix1 = skid;
    else if (take_fifo)
      pix1 = fifo_do[15:0];
`ifdef LCD_TEST_PATTERN_EN
    if (tp1)
      pix1 = pat1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      state         <= S_RESYNC;
      in_sync       <= 1'b0;
      skid          <= '0;
      skid_valid    <= 1'b0;
      pop_pending   <= 1'b0;
      act1          <= 1'b0;
      hs1           <= 1'b0;
      vs1           <= 1'b0;
      origin1       <= 1'b0;
      skid_src1     <= 1'b0;
      lcd_de        <= 1'b0;
      lcd_hsync     <= ~SYNC_POL;
      lcd_vsync     <= ~SYNC_POL;
      lcd_r         <= '0;
      lcd_g         <= '0;
      lcd_b         <= '0;
      underflow_cnt <= '0;
      resync_cnt    <= '0;
`ifdef LCD_TEST_PATTERN_EN
      tp1           <= 1'b0;
      pat1          <= '0;
`endif
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      pop_pending <= fifo_re;
      act1        <= active0;
      hs1         <= hs0;
      vs1         <= vs0;
      origin1     <= origin0;
      skid_src1   <= !tp && (state == S_WAIT_FRAME) && origin0 && skid_valid;
`ifdef LCD_TEST_PATTERN_EN
      tp1         <= tp;
      pat1        <= pat0;
`endif

      lcd_de    <= act1;
      lcd_hsync <= hs1 ? SYNC_POL : ~SYNC_POL;
      lcd_vsync <= vs1 ? SYNC_POL : ~SYNC_POL;
      if (act1) begin
        lcd_r <= pix1[15:11];
        lcd_g <= pix1[10:5];
        lcd_b <= pix1[4:0];
      end else begin
        lcd_r <= '0;
        lcd_g <= '0;
        lcd_b <= '0;
      end

      if (!tp && (state == S_RUN) && active0 && fifo_empty && (underflow_cnt != 16'hFFFF))
        underflow_cnt <= underflow_cnt + 1'b1;

      if (!tp) begin
        case (state)
          S_RESYNC: begin
            if (pop_pending && sof1) begin
              skid       <= fifo_do[15:0];
              skid_valid <= 1'b1;
              state      <= S_WAIT_FRAME;
            end
          end
          S_WAIT_FRAME: begin
            if (origin0) begin
              skid_valid <= 1'b0;
              state      <= S_RUN;
              in_sync    <= 1'b1;
            end
          end
          S_RUN: begin
            if (leave_run) begin
              in_sync <= 1'b0;
              if (resync_cnt != 8'hFF)
                resync_cnt <= resync_cnt + 1'b1;
              if (origin1) begin
                state <= S_RESYNC;
              end else begin
                skid       <= fifo_do[15:0];
                skid_valid <= 1'b1;
                state      <= S_WAIT_FRAME;
              end
            end
          end
          default: state <= S_RESYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_fifo_reader.sv
// Directed bench for lcd_fifo_reader on a shrunken 16x7 raster (8x4 active) fed by a FIFO model.
module tb_lcd_fifo_reader;
  localparam logic [15:0] FILL = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] fifo_do = '0;
  logic        fifo_empty;
  logic        fifo_re, lcd_de, lcd_hsync, lcd_vsync, in_sync;
  logic [4:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [4:0]  lcd_b;
  logic [15:0] underflow_cnt;
  logic [7:0]  resync_cnt;
  logic [15:0] rgb;
`ifdef LCD_TEST_PATTERN_EN
  logic        test_pat = 1'b0;
`endif

  logic [19:0] mem [0:511];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        force_empty = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  assign rgb        = {lcd_r, lcd_g, lcd_b};
  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  // FIFO without output register: data appears the cycle after the pop
  always @(posedge clk) begin
    if (fifo_re && !fifo_empty) begin
      fifo_do <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  lcd_fifo_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .FILL_RGB(FILL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_do(fifo_do),
    .fifo_empty(fifo_empty),
`ifdef LCD_TEST_PATTERN_EN
    .test_pat(test_pat),
`endif
    .fifo_re(fifo_re),
    .lcd_de(lcd_de),
    .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync),
    .lcd_r(lcd_r),
    .lcd_g(lcd_g),
    .lcd_b(lcd_b),
    .in_sync(in_sync),
    .underflow_cnt(underflow_cnt),
    .resync_cnt(resync_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] base, input int n, input bit sof0);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = {3'b000, (i == 0) && sof0, base + 16'(i)};
      wr_ptr++;
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Cycle C(k+2) shows the pixel at counter index k; origin of frame f is k=112*f.
  initial begin
    rst_n = 1'b0;
    load(16'h0000, 32, 1'b1);
    load(16'h2000, 22, 1'b1);
    load(16'h3000, 32, 1'b1);
    load(16'h4000, 32, 1'b0);
    load(16'h5000, 32, 1'b1);
    load(16'h6000, 19, 1'b1);
    load(16'h7000, 32, 1'b1);
    load(16'h8000, 32, 1'b1);
    load(16'h9000, 32, 1'b1);
    load(16'hB000, 32, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_re",    32'(fifo_re), 32'd0);
    chk("rst_de",    32'(lcd_de), 32'd0);
    chk("rst_hs",    32'(lcd_hsync), 32'd1);
    chk("rst_vs",    32'(lcd_vsync), 32'd1);
    chk("rst_rgb",   32'(rgb), 32'd0);
    chk("rst_sync",  32'(in_sync), 32'd0);
    chk("rst_uf",    32'(underflow_cnt), 32'd0);
    chk("rst_rs",    32'(resync_cnt), 32'd0);
    rst_n = 1'b1;
    cyc = 0;

    // frame 0: hunting, fill on active pixels
    goto(2);   chk("f0_de", 32'(lcd_de), 32'd1); chk("f0_fill", 32'(rgb), 32'(FILL));
    goto(12);  chk("f0_blank_de", 32'(lcd_de), 32'd0); chk("f0_blank_rgb", 32'(rgb), 32'd0);
    goto(81);  chk("vs_before", 32'(lcd_vsync), 32'd1);
    goto(82);  chk("vs_first", 32'(lcd_vsync), 32'd0);
    goto(97);  chk("vs_last", 32'(lcd_vsync), 32'd0);
    goto(98);  chk("vs_after", 32'(lcd_vsync), 32'd1);

    // frame 1: first locked frame from skid
    goto(113); chk("f1_sync", 32'(in_sync), 32'd1); chk("f1_de_pre", 32'(lcd_de), 32'd0);
    goto(114); chk("f1_de_rise", 32'(lcd_de), 32'd1); chk("f1_px0", 32'(rgb), 32'h0000);
    goto(115); chk("f1_px1", 32'(rgb), 32'h0001);
    goto(121); chk("f1_px7", 32'(rgb), 32'h0007);
    goto(122); chk("f1_de_fall", 32'(lcd_de), 32'd0);
    goto(123); chk("hs_before", 32'(lcd_hsync), 32'd1);
    goto(124); chk("hs_first", 32'(lcd_hsync), 32'd0);
    goto(126); chk("hs_last", 32'(lcd_hsync), 32'd0);
    goto(127); chk("hs_after", 32'(lcd_hsync), 32'd1);
    goto(130); chk("f1_px8", 32'(rgb), 32'h0008);
    goto(169); chk("f1_px31", 32'(rgb), 32'h001F);

    // frame 2: underflow window of 10 active pixels
    goto(226); chk("f2_px0", 32'(rgb), 32'h2000);
    goto(244); force_empty = 1'b1;
    goto(245); chk("f2_px11", 32'(rgb), 32'h200B);
    goto(246); chk("f2_uf_first", 32'(rgb), 32'(FILL));
    goto(262); force_empty = 1'b0;
    goto(263); chk("f2_uf_last", 32'(rgb), 32'(FILL));
    goto(264); chk("f2_shift", 32'(rgb), 32'h200C);
    goto(281); chk("f2_tail", 32'(rgb), 32'h2015);
    goto(282); chk("uf_cnt", 32'(underflow_cnt), 32'd10); chk("uf_sync", 32'(in_sync), 32'd1);

    // frame 3: realigned without resync
    goto(338); chk("f3_px0", 32'(rgb), 32'h3000); chk("f3_rs", 32'(resync_cnt), 32'd0);
    chk("f3_sync", 32'(in_sync), 32'd1);
    goto(345); chk("f3_px7", 32'(rgb), 32'h3007);

    // frame 4: word 0 without SOF
    goto(449); chk("f4_re_block", 32'(fifo_re), 32'd0);
    goto(450); chk("f4_px0_fill", 32'(rgb), 32'(FILL)); chk("f4_rs", 32'(resync_cnt), 32'd1);
    chk("f4_sync", 32'(in_sync), 32'd0);
    goto(470); chk("f4_fill", 32'(rgb), 32'(FILL));
    goto(520); chk("f4_wait_re", 32'(fifo_re), 32'd0);
    goto(561); chk("f5_sync", 32'(in_sync), 32'd1);
    goto(562); chk("f5_px0", 32'(rgb), 32'h5000);
    goto(563); chk("f5_px1", 32'(rgb), 32'h5001);

    // frame 6: SOF arrives at pixel (3,2)
    goto(708); chk("f6_px18", 32'(rgb), 32'h6012); chk("f6_re_block", 32'(fifo_re), 32'd0);
    goto(709); chk("f6_sof_fill", 32'(rgb), 32'(FILL)); chk("f6_rs", 32'(resync_cnt), 32'd2);
    chk("f6_sync", 32'(in_sync), 32'd0);
    goto(710); chk("f6_next_fill", 32'(rgb), 32'(FILL));
    goto(750); chk("f6_wait_re", 32'(fifo_re), 32'd0);
    goto(786); chk("f7_px0", 32'(rgb), 32'h7000);
    goto(787); chk("f7_px1", 32'(rgb), 32'h7001); chk("f7_uf", 32'(underflow_cnt), 32'd10);

    // mid-frame reset at pixel (5,2) of frame 8
    goto(933); rst_n = 1'b0;
    #1; chk("mr_re", 32'(fifo_re), 32'd0);
    goto(934); rst_n = 1'b1;
    chk("mr_de", 32'(lcd_de), 32'd0);
    chk("mr_hs", 32'(lcd_hsync), 32'd1);
    chk("mr_vs", 32'(lcd_vsync), 32'd1);
    chk("mr_rgb", 32'(rgb), 32'd0);
    chk("mr_sync", 32'(in_sync), 32'd0);
    chk("mr_uf", 32'(underflow_cnt), 32'd0);
    chk("mr_rs", 32'(resync_cnt), 32'd0);
    goto(935); chk("mr_pipe_de", 32'(lcd_de), 32'd0);
    goto(936); chk("mr_de0", 32'(lcd_de), 32'd1); chk("mr_fill0", 32'(rgb), 32'(FILL));
    goto(946); chk("mr_hs_restart", 32'(lcd_hsync), 32'd0);
    goto(1047); chk("mr_relock", 32'(in_sync), 32'd1);
    goto(1048); chk("mr_px0", 32'(rgb), 32'h9000);

`ifdef LCD_TEST_PATTERN_EN
    goto(1100); test_pat = 1'b1;
    goto(1158); chk("tp_re", 32'(fifo_re), 32'd0);
    goto(1160); chk("tp_white", 32'(rgb), 32'hFFFF);
    goto(1161); chk("tp_yellow", 32'(rgb), 32'hFFE0);
    goto(1162); chk("tp_cyan", 32'(rgb), 32'h07FF);
    goto(1167); chk("tp_black", 32'(rgb), 32'h0000); chk("tp_de", 32'(lcd_de), 32'd1);
    chk("tp_sync", 32'(in_sync), 32'd1);
`endif

    goto(1200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
